// File: rtl/mdu_seq.sv
// Sequential unsigned multiply/divide unit: shift-add MULTU and restoring DIVU,
// 32 iterations per operation, result written back to the br register file.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  input  logic [4:0]       DestReg,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [4:0]       WriteReg,
  output logic [WIDTH-1:0] WriteData,
  output logic             RegWrite
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 op_q, op_d;
  logic [4:0]           dest_q, dest_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // acc holds {carry, P_hi, P_lo} for MULTU and {R[32:0], Q} for DIVU
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH:0]     mul_next;
  logic [2*WIDTH:0]     div_shift;
  logic [WIDTH+1:0]     div_trial;
  logic [2*WIDTH:0]     div_next;
  logic [2*WIDTH:0]     acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:0], 1'b0};
    div_trial = {1'b0, div_shift[2*WIDTH:WIDTH]} - {2'b00, b_q};
    div_next  = div_trial[WIDTH+1] ? div_shift
                                   : {div_trial[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};
    acc_step  = op_q ? div_next : mul_next;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    dest_d  = dest_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          acc_d  = {{(WIDTH+1){1'b0}}, RD1};
          b_d    = RD2;
          op_d   = Op;
          dest_d = DestReg;
          cnt_d  = '0;
          if (Op && (RD2 == '0)) begin
            hi_d    = RD1;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          hi_d    = acc_step[2*WIDTH-1:WIDTH];
          lo_d    = acc_step[WIDTH-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      dest_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // outputs decode only flops, so there is no input-to-output path
  assign Busy      = (state_q == S_RUN);
  assign Done      = (state_q == S_DONE);
  assign RegWrite  = (state_q == S_DONE) && (dest_q != 5'd0);
  assign WriteReg  = dest_q;
  assign WriteData = lo_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: vector table through a result scoreboard,
// plus hand sequences for busy-time Start, back-to-back Start and mid-run reset.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic        Op;
  logic [31:0] RD1, RD2;
  logic [4:0]  DestReg;
  logic        Busy, Done, RegWrite;
  logic [31:0] HI, LO, WriteData;
  logic [4:0]  WriteReg;

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .RD1(RD1), .RD2(RD2),
    .DestReg(DestReg), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [4:0]  dest;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  dest;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic op, input logic [4:0] dest);
    vec_t v;
    logic [63:0] p;
    v.a = a; v.b = b; v.op = op; v.dest = dest;
    if (!op) begin
      p = {32'd0, a} * {32'd0, b};
      v.hi = p[63:32];
      v.lo = p[31:0];
    end else if (b == 32'd0) begin
      v.hi = a;
      v.lo = 32'hFFFF_FFFF;
    end else begin
      v.hi = a % b;
      v.lo = a / b;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one operation; glitch_at > 0 pulses Start with junk operands at that cycle
  task automatic run_op(input vec_t v, input int glitch_at);
    exp_t e;
    int   n;
    int   busy_cnt;
    e.hi = v.hi; e.lo = v.lo; e.dest = v.dest;
    e.lat = (v.op && v.b == 32'd0) ? 1 : 33;
    sb.push_back(e);
    RD1 = v.a; RD2 = v.b; Op = v.op; DestReg = v.dest; Start = 1'b1;
    tick();
    Start = 1'b0; RD1 = $urandom; RD2 = $urandom; DestReg = 5'd29;
    n = 1;
    busy_cnt = 0;
    while (!Done && n < 40) begin
      if (Busy) busy_cnt++;
      if (n == glitch_at) begin
        Start = 1'b1; Op = ~v.op; RD1 = $urandom; RD2 = $urandom; DestReg = 5'd17;
      end else begin
        Start = 1'b0;
      end
      tick();
      n++;
    end
    Start = 1'b0;
    e = sb.pop_front();
    check("done", {63'd0, Done}, 64'd1);
    check("latency", 64'(n), 64'(e.lat));
    check("busy_cycles", 64'(busy_cnt), (e.lat == 1) ? 64'd0 : 64'd32);
    check("hi", {32'd0, HI}, {32'd0, e.hi});
    check("lo", {32'd0, LO}, {32'd0, e.lo});
    check("write_data", {32'd0, WriteData}, {32'd0, e.lo});
    check("write_reg", {59'd0, WriteReg}, {59'd0, e.dest});
    check("reg_write", {63'd0, RegWrite}, {63'd0, (e.dest != 5'd0)});
    tick();
    check("done_pulse_end", {62'd0, Done, RegWrite}, 64'd0);
    check("idle_not_busy", {63'd0, Busy}, 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; Start = 1'b1; Op = 1'b0; RD1 = 32'd3; RD2 = 32'd4; DestReg = 5'd1;
    tick();
    tick();
    check("rst_flags", {61'd0, Busy, Done, RegWrite}, 64'd0);
    check("rst_hi_lo", {HI, LO}, 64'd0);
    check("rst_wb", {27'd0, WriteReg, WriteData}, 64'd0);
    rst = 1'b0; Start = 1'b0;
    tick();

    vecs[0] = '{a: 32'd7,          b: 32'd6,          op: 1'b0, dest: 5'd3,
                hi: 32'd0,          lo: 32'd42};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  op: 1'b0, dest: 5'd7,
                hi: 32'hFFFF_FFFE,  lo: 32'h0000_0001};
    vecs[2] = '{a: 32'd100,        b: 32'd7,          op: 1'b1, dest: 5'd5,
                hi: 32'd2,          lo: 32'd14};
    vecs[3] = '{a: 32'd5,          b: 32'd0,          op: 1'b1, dest: 5'd9,
                hi: 32'd5,          lo: 32'hFFFF_FFFF};
    vecs[4] = mk(32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 5'd1);
    vecs[5] = mk(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 5'd31);
    vecs[6] = mk(32'd3,         32'd5,         1'b1, 5'd2);
    vecs[7] = mk(32'hFFFF_FFFF, 32'd1,         1'b1, 5'd4);
    vecs[8] = mk(32'd0,         32'd123,       1'b0, 5'd6);
    vecs[9] = mk(32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 5'd12);

    for (int i = 0; i < 10; i++) run_op(vecs[i], 0);

    // Start during Busy is ignored; DestReg = 0 suppresses RegWrite
    run_op(mk(32'd1000, 32'd33, 1'b1, 5'd0), 10);
    run_op(mk(32'hCAFE_F00D, 32'd3, 1'b0, 5'd0), 10);

    // Start held high through DONE: second op accepted at the first IDLE edge
    sb.push_back('{hi: 32'd2, lo: 32'd14, dest: 5'd5, lat: 33});
    sb.push_back('{hi: 32'd0, lo: 32'd42, dest: 5'd3, lat: 67});
    RD1 = 32'd100; RD2 = 32'd7; Op = 1'b1; DestReg = 5'd5; Start = 1'b1;
    tick();
    n = 1;
    while (sb.size() > 0 && n < 80) begin
      if (Done) begin
        exp_t e;
        e = sb.pop_front();
        check("b2b_latency", 64'(n), 64'(e.lat));
        check("b2b_result", {HI, LO}, {e.hi, e.lo});
        check("b2b_write_reg", {59'd0, WriteReg}, {59'd0, e.dest});
        RD1 = 32'd7; RD2 = 32'd6; Op = 1'b0; DestReg = 5'd3;
      end
      if (n == 34) check("b2b_idle_gap", {63'd0, Busy}, 64'd0);
      tick();
      n++;
    end
    Start = 1'b0;
    check("b2b_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    tick();
    tick();

    // reset mid-MULTU abandons the operation
    RD1 = 32'd11; RD2 = 32'd13; Op = 1'b0; DestReg = 5'd8; Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 1;
    while (n < 15) begin
      tick();
      n++;
    end
    check("busy_before_rst", {63'd0, Busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", {63'd0, Busy}, 64'd0);
    check("rst_mid_hi_lo", {HI, LO}, 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (Done || RegWrite || Busy) seen++;
      tick();
    end
    check("rst_no_done", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Sequential unsigned multiply/divide unit that sits directly downstream of the `br` register file. It takes operands from `br` read ports RD1/RD2 and returns its 32-bit result to `br` through a WriteReg/WriteData/RegWrite write-back port. The 64-bit result is also held in HI/LO registers. One operation is in flight at a time, with a Start/Busy/Done handshake.

## Interface
- WIDTH, 32, operand width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- Start  in  1  operation request; sampled only in IDLE.
- Op  in  1  0 = MULTU, 1 = DIVU.
- RD1  in  32  operand A (multiplicand / dividend), from br RD1.
- RD2  in  32  operand B (multiplier / divisor), from br RD2.
- DestReg  in  5  write-back register index, captured with the operands.
- Busy  out  1  high while computing (RUN state).
- Done  out  1  one-cycle pulse when the result is valid.
- HI  out  32  MULTU: product[63:32]; DIVU: remainder.
- LO  out  32  MULTU: product[31:0]; DIVU: quotient.
- WriteReg  out  5  to br WriteReg.
- WriteData  out  32  to br WriteData; always equals LO.
- RegWrite  out  1  to br RegWrite; one-cycle pulse.

## Operation
- States: IDLE, RUN, DONE. Counter `cnt` is 6 bits.
- IDLE, with Start = 1:
  - Capture A = RD1, B = RD2, Dest = DestReg, op = Op.
  - Clear `cnt`.
  - If op = DIVU and B = 0, go to DONE; otherwise go to RUN.
- IDLE, with Start = 0: stay in IDLE.
- RUN, MULTU (shift-add):
  - 65-bit accumulator {carry, P_hi, P_lo}, initialised with P_lo = A and P_hi = 0.
  - Each cycle: if P_lo[0] = 1, {carry, P_hi} += B. Then shift the whole accumulator right by 1.
- RUN, DIVU (restoring):
  - 33-bit remainder R, initialised to 0; quotient register Q, initialised to A.
  - Each cycle: shift {R, Q} left by 1 and trial-subtract R − B.
  - If the result is non-negative, keep it and set Q[0] = 1; otherwise restore R and set Q[0] = 0.
- RUN exit: after exactly 32 RUN cycles (cnt = 31 at the exit edge), go to DONE.
- Leaving RUN: HI/LO load the final results (MULTU: P_hi/P_lo; DIVU: R[31:0]/Q).
- Divide by zero: HI = A, LO = 32'hFFFFFFFF, with no RUN cycles.
- DONE (exactly one cycle):
  - Done = 1.
  - RegWrite = 1 unless Dest = 0, in which case it is suppressed.
  - WriteReg = Dest, WriteData = LO.
  - Next state is IDLE unconditionally.
- Start is ignored in RUN and DONE. No queuing; the requester must wait for Done.
- HI/LO hold their values until the next completion or until reset.
- Op values are unsigned only; no sign handling.

## Timing
- Reset (synchronous, at a clk edge with rst = 1):
  - State = IDLE, cnt = 0.
  - Busy = 0, Done = 0, RegWrite = 0.
  - HI = 0, LO = 0, WriteReg = 0, WriteData = 0.
  - Reset overrides Start.
- Reset mid-RUN or mid-DONE: the operation is abandoned, with no Done or RegWrite pulse and HI/LO = 0.
- Start sampled high at edge N (in IDLE):
  - Busy is 1 for cycles N+1 … N+32.
  - DONE is at cycle N+33: Done, RegWrite and the final HI/LO are visible there.
  - IDLE at N+34.
  - Total latency is 33 cycles.
- Divide by zero: DONE at N+1 and Busy never asserts. Total latency is 1 cycle.
- Back-to-back: Start held high through DONE is accepted at the first IDLE edge (N+34). The throughput bound is 1 operation per 34 cycles.
- All outputs are registered. There is no combinational path from the inputs to the outputs.
- RegWrite is a single-cycle pulse aligned with Done. br latches WriteData at that edge.

## Test plan
- MULTU: RD1 = 7, RD2 = 6, DestReg = 3, Start at N → Done and RegWrite at N+33, HI = 0, LO = WriteData = 42, WriteReg = 3.
- MULTU: RD1 = RD2 = 32'hFFFFFFFF → HI = 32'hFFFFFFFE, LO = 32'h00000001.
- DIVU: RD1 = 100, RD2 = 7, DestReg = 5 → LO = 14, HI = 2, WriteReg = 5, Done at N+33.
- DIVU by zero: RD1 = 5, RD2 = 0 → Done at N+1, Busy never high, LO = 32'hFFFFFFFF, HI = 5.
- Start pulsed with new operands at N+10 (during Busy) → ignored; the result matches the first operation. DestReg = 0 → Done pulses but RegWrite stays 0.
- rst asserted at N+15 mid-MULTU → next cycle Busy = 0, HI = LO = 0; no Done or RegWrite through N+40.
